// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider -- sequential signed 8-bit divider (restoring, one quotient bit/clk)
//
// Converts both operands to 8-bit magnitudes on start. It runs eight restoring
// steps MSB first, then applies the two's-complement sign fix in a final FIX
// cycle. Quotient truncates toward zero and the remainder takes the sign of
// the dividend. Exception cases (divide by zero, -128 / -1) are flagged.
//
// Configuration macro:
//   DIVIDER_SAT_EN  defined   -> both exception cases saturate the quotient
//                   undefined -> wrap behaviour, no saturation logic built
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   start        in   1  operation request, sampled only in IDLE
//   dividend     in   8  signed dividend
//   divisor      in   8  signed divisor
//   quotient     out  8  signed quotient, registered
//   remainder    out  8  signed remainder, registered
//   busy         out  1  operation in flight (CALC or FIX)
//   done         out  1  one-cycle completion pulse
//   div_by_zero  out  1  last operation had divisor == 0
//   ovf          out  1  last operation was -128 / -1
// -----------------------------------------------------------------------------
module divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t     state_q, state_d;

  // Datapath: partial remainder and a shared shift register. The register
  // starts holding the dividend magnitude. Quotient bits shift in from the
  // right as dividend bits shift out on the left.
  logic [7:0] prem_q,  prem_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] dvs_q,   dvs_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       sgn_quo_q, sgn_quo_d;
  logic       sgn_rem_q, sgn_rem_d;
  logic       zero_q,    zero_d;
  logic       ovfc_q,    ovfc_d;

  // Registered results.
  logic [7:0] quotient_q,  quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       done_q,      done_d;
  logic       dz_q,        dz_d;
  logic       ovf_q,       ovf_d;

  // Restoring-step helpers.
  logic [8:0] trial;
  logic [8:0] diff;
  logic [7:0] q_neg;
  logic [7:0] r_neg;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prem_q      <= 8'h00;
      shreg_q     <= 8'h00;
      dvs_q       <= 8'h00;
      cnt_q       <= 3'd0;
      sgn_quo_q   <= 1'b0;
      sgn_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      ovfc_q      <= 1'b0;
      quotient_q  <= 8'h00;
      remainder_q <= 8'h00;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prem_q      <= prem_d;
      shreg_q     <= shreg_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      sgn_quo_q   <= sgn_quo_d;
      sgn_rem_q   <= sgn_rem_d;
      zero_q      <= zero_d;
      ovfc_q      <= ovfc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (divisor == 8'h00) ? FIX : CALC;
      CALC: if (cnt_q == 3'd7) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture and restoring steps
  // ---------------------------------------------------------------------------
  // prem_q < divisor magnitude <= 128, so the shifted trial value is at most
  // 255. Bit 8 of the 9-bit difference is therefore a reliable sign bit.
  assign trial = {prem_q, shreg_q[7]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    prem_d    = prem_q;
    shreg_d   = shreg_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    zero_d    = zero_q;
    ovfc_d    = ovfc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // |-128| is 8'h80 = 128 unsigned, so negating is exact here.
          shreg_d   = dividend[7] ? (~dividend + 8'd1) : dividend;
          dvs_d     = divisor[7]  ? (~divisor  + 8'd1) : divisor;
          prem_d    = 8'h00;
          cnt_d     = 3'd0;
          sgn_quo_d = dividend[7] ^ divisor[7];
          sgn_rem_d = dividend[7];
          zero_d    = (divisor == 8'h00);
          ovfc_d    = (dividend == 8'h80) && (divisor == 8'hFF);
        end
      end
      CALC: begin
        cnt_d = cnt_q + 3'd1;
        if (!diff[8]) begin
          prem_d  = diff[7:0];
          shreg_d = {shreg_q[6:0], 1'b1};
        end else begin
          prem_d  = trial[7:0];
          shreg_d = {shreg_q[6:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: sign fix and exception handling in FIX
  // ---------------------------------------------------------------------------
  // In a divide-by-zero operation CALC never ran. shreg_q still holds the
  // dividend magnitude, so applying sign_r restores the original dividend.
  assign q_neg = ~shreg_q + 8'd1;
  assign r_neg = ~prem_q  + 8'd1;

  always_comb begin
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    busy        = (state_q != IDLE);
    if (state_q == FIX) begin
      done_d = 1'b1;
      dz_d   = zero_q;
      ovf_d  = ovfc_q;
      if (zero_q) begin
        remainder_d = sgn_rem_q ? q_neg : shreg_q;
`ifdef DIVIDER_SAT_EN
        quotient_d  = sgn_rem_q ? 8'h80 : 8'h7F;
`else
        quotient_d  = 8'hFF;
`endif
      end else begin
        remainder_d = sgn_rem_q ? r_neg : prem_q;
`ifdef DIVIDER_SAT_EN
        quotient_d  = ovfc_q ? 8'h7F : (sgn_quo_q ? q_neg : shreg_q);
`else
        // -128 / -1 gives magnitude 128 with a positive sign. It wraps to 8'h80.
        quotient_d  = sgn_quo_q ? q_neg : shreg_q;
`endif
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider
//
// Expected results come from plain signed integer division on the operands.
// Exception cases are handled the way the divider's contract defines them.
// Compile with +define+DIVIDER_SAT_EN to check the saturating build.
// -----------------------------------------------------------------------------
module tb_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero, ovf;

  int vectors    = 0;
  int miscompares = 0;

  // Values the outputs must still show until the next FIX.
  logic [7:0] hold_q, hold_r;
  logic       hold_dz, hold_ovf;

  divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: signed integer arithmetic plus the exception rules.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (bi == 0) begin
      dz = 1'b1;
      ri = ai;
`ifdef DIVIDER_SAT_EN
      qi = (ai >= 0) ? 127 : -128;
`else
      qi = -1;
`endif
    end else if (ai == -128 && bi == -1) begin
      ov = 1'b1;
      ri = 0;
`ifdef DIVIDER_SAT_EN
      qi = 127;
`else
      qi = 128;
`endif
    end else begin
      qi = ai / bi;
      ri = ai % bi;
    end
    q = qi[7:0];
    r = ri[7:0];
  endtask

  // Issues one operation (start high for one cycle) and checks the handshake
  // timing and results. The call returns in the done cycle, so a following
  // call issues its start back to back.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input string name);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         edges, busy_cnt, lat;
    model(a, b, eq, er, edz, eov);
    lat = (b == 8'h00) ? 1 : 9;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || quotient !== hold_q || remainder !== hold_r
        || div_by_zero !== hold_dz || ovf !== hold_ovf) begin
      miscompares++;
      $display("FAIL %s accept: busy=%b done=%b q=%h r=%h dz=%b ovf=%b, required busy=1 done=0 q=%h r=%h dz=%b ovf=%b",
               name, busy, done, quotient, remainder, div_by_zero, ovf, hold_q, hold_r, hold_dz, hold_ovf);
    end
    edges = 0; busy_cnt = 0;
    while (done !== 1'b1 && edges < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    vectors++;
    if (edges != lat || busy_cnt != lat) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d edges, busy %0d cycles, required %0d and %0d",
               name, edges, busy_cnt, lat, lat);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_with_done: busy=%b, required 0", name, busy);
    end
    vectors++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edz || ovf !== eov) begin
      miscompares++;
      $display("FAIL %s result %h/%h: q=%h r=%h dz=%b ovf=%b, required q=%h r=%h dz=%b ovf=%b",
               name, a, b, quotient, remainder, div_by_zero, ovf, eq, er, edz, eov);
    end
    hold_q = eq; hold_r = er; hold_dz = edz; hold_ovf = eov;
  endtask

  task automatic check_zero_outputs(input string name);
    vectors++;
    if (quotient !== 8'h00 || remainder !== 8'h00 || busy !== 1'b0 || done !== 1'b0
        || div_by_zero !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: q=%h r=%h busy=%b done=%b dz=%b ovf=%b, required all 0",
               name, quotient, remainder, busy, done, div_by_zero, ovf);
    end
    hold_q = 8'h00; hold_r = 8'h00; hold_dz = 1'b0; hold_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    #1;
    check_zero_outputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(8'd100, 8'd7,   "100/7");
    do_op(8'h9C,  8'd7,   "-100/7");
    do_op(8'd100, 8'hF9,  "100/-7");
    do_op(8'h80,  8'hFF,  "-128/-1");
    do_op(8'd127, 8'hFF,  "127/-1");
    do_op(8'd55,  8'h00,  "55/0");
    do_op(8'h80,  8'h00,  "-128/0");
    do_op(8'h80,  8'd1,   "-128/1");
    do_op(8'h80,  8'h80,  "-128/-128");
    do_op(8'd5,   8'h80,  "5/-128");
    do_op(8'h00,  8'd3,   "0/3");
  endtask

  // Two div-by-zero operations back to back, then two normal ones. Each start
  // lands in the previous done cycle.
  task automatic test_back_to_back();
    do_op(8'h11, 8'h00, "b2b_dz0");
    do_op(8'hEE, 8'h00, "b2b_dz1");
    do_op(8'd77, 8'd9,  "b2b_n0");
    do_op(8'hB5, 8'hFD, "b2b_n1");
  endtask

  // A second start at E3 must be ignored.
  task automatic test_busy_ignore();
    int edges;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;          // E0
    repeat (2) @(posedge clk);                  // E1, E2
    @(negedge clk); dividend = 8'h80; divisor = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;           // E3
    edges = 3;
    while (done !== 1'b1 && edges < 25) begin
      @(posedge clk); #1; edges++;
    end
    vectors++;
    if (edges != 9 || quotient !== 8'h0E || remainder !== 8'h02 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore: done at edge %0d q=%h r=%h dz=%b, required edge 9 q=0e r=02 dz=0",
               edges, quotient, remainder, div_by_zero);
    end
    hold_q = 8'h0E; hold_r = 8'h02; hold_dz = 1'b0; hold_ovf = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  // Reset at E5 clears everything at once and suppresses done.
  task automatic test_reset_mid();
    int seen;
    do_op(8'h9C, 8'd3, "pre_reset");
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;           // E0
    repeat (5) @(posedge clk);                  // E1..E5
    #1 rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid");
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: %0d cycles with done/busy after reset, required 0", seen);
    end
    do_op(8'd9, 8'd3, "9/3_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       begin a = 8'($urandom); b = 8'h00; end
        1:       begin a = 8'h80;        b = 8'hFF; end
        2:       begin a = 8'h80;        b = 8'($urandom); end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      do_op(a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential signed 8-bit divider: the inverse operation to the team's combinational Booth multiplier, sharing its operand width and two's-complement convention. It takes a dividend/divisor pair on a start pulse and iterates one quotient bit per clock using restoring division on magnitudes, then applies a sign fix. It returns quotient, remainder and status with a start/busy/done handshake, and sits beside the multiplier in the processor's arithmetic unit.

## Interface
- No parameters. Width is fixed at 8 bits to match the multiplier.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  8  signed dividend
- divisor  in  8  signed divisor
- quotient  out  8  signed quotient, registered
- remainder  out  8  signed remainder, registered
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  last operation had divisor == 0
- ovf  out  1  last operation was -128 / -1

## Operation
- States: IDLE, CALC, FIX.
- **IDLE + start:**
  - Latch |dividend|, |divisor|, sign_q = dividend[7]^divisor[7], sign_r = dividend[7].
  - Clear the partial remainder and set iteration count = 0.
  - busy goes high.
  - If divisor == 0, go to FIX with the zero flag set. Otherwise go to CALC.
- **CALC:** one restoring step per clock, 8 steps, MSB first.
  - Shift {partial_rem, dividend_mag} left by 1.
  - Trial-subtract the divisor magnitude using a 9-bit difference.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - After count reaches 7, go to FIX.
- **FIX:** register the outputs, pulse done, drop busy, return to IDLE.
  - quotient = sign_q ? -q_mag : q_mag, truncated to 8 bits.
  - remainder = sign_r ? -r_mag : r_mag.
- **Arithmetic rules:**
  - Quotient truncates toward zero. The remainder takes the dividend's sign.
  - dividend == quotient*divisor + remainder holds whenever div_by_zero = 0 and ovf = 0.
  - Magnitudes are 8-bit unsigned, so |-128| = 128 is represented exactly.
- **ovf:** set when dividend = 8'h80 and divisor = 8'hFF. The true quotient (+128) wraps to 8'h80 and the remainder is 0.
- **div_by_zero (DIVIDER_SAT_EN undefined):** quotient = 8'hFF, remainder = dividend, ovf = 0.
- **Handshake:**
  - start is ignored while busy.
  - start is accepted in the same cycle done is high, because the block is already in IDLE.
  - Operands only need to be valid in the cycle start is sampled.
- **Status outputs:** quotient, remainder, div_by_zero and ovf hold their values until the next FIX.

## Timing
- Reset: state IDLE; quotient, remainder, busy, done, div_by_zero, ovf all 0.
- Reset takes effect immediately and works mid-operation. The in-flight result is discarded and no done pulse is produced.
- Normal latency:
  - start is sampled at edge E0.
  - CALC runs over edges E1–E8.
  - FIX at edge E9 updates the outputs and raises done. done stays high for exactly one cycle, until E10.
- busy is high after E0 and low after E9. It is never high in the same cycle as done.
- Divide-by-zero latency: FIX at E1, so done is high after E1.
- Throughput: one operation every 10 clocks with back-to-back starts; every 2 clocks for divide-by-zero.

## Configuration
- DIVIDER_SAT_EN defined: both exception cases saturate.
  - -128 / -1 gives quotient 8'h7F, remainder 0, ovf = 1.
  - Divide-by-zero gives quotient 8'h7F if dividend ≥ 0, else 8'h80; remainder = dividend; div_by_zero = 1.
- DIVIDER_SAT_EN undefined: wrap behaviour exactly as described in Operation. No saturation logic is synthesised.

## Test plan
- 100 / 7, start for one cycle → done after the 10th edge; quotient 8'h0E, remainder 8'h02, flags 0; busy high for exactly 9 cycles.
- -100 / 7 and 100 / -7 → quotient 8'hF2 for both; remainder 8'hFE and 8'h02 respectively.
- -128 / -1 → ovf = 1, remainder 0; quotient 8'h80 without DIVIDER_SAT_EN, 8'h7F with it. 127 / -1 → 8'h81, ovf = 0.
- 55 / 0 → done after the 2nd edge; div_by_zero = 1, remainder 8'h37; quotient 8'hFF without the macro, 8'h7F with it.
- start pulsed with new operands at E3 of an operation → ignored, first result unchanged. A new start in the done cycle is accepted, and its done arrives 10 edges later.
- rst asserted at E5 → outputs 0 immediately, no done pulse. After release, 9 / 3 → quotient 8'h03, remainder 0.
